tmds_decoder: RTL and testbench

- Receive-side counterpart of the TMDS encoder. Takes unaligned 10-bit words from a 1:10 deserializer for one TMDS channel.
- Finds the symbol boundary by hunting for control-token runs, then decodes each symbol to 8-bit pixel data, 2-bit control and display enable.
- Sits between the deserializer primitive and the video timing recovery logic; one instance per channel.

---
 rtl/tmds_pkg.sv | 18 +
 rtl/tmds_symbol_decode.sv | 36 +++
 rtl/tmds_decoder.sv | 149 ++++++++++++++
 tb/tb_tmds_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants and alignment state type
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [3:0] OFFSET_MAX = 4'd9;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol decode to control token or pixel byte
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctrl,
  output logic [1:0]       o_ctrl,
  output logic [7:0]       o_data
);

  logic [7:0] w_q;

  assign w_q = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_sym)
      CTRL_TOKEN_00: o_ctrl = 2'b00;
      CTRL_TOKEN_01: o_ctrl = 2'b01;
      CTRL_TOKEN_10: o_ctrl = 2'b10;
      CTRL_TOKEN_11: o_ctrl = 2'b11;
      default:       o_is_ctrl = 1'b0;
    endcase
  end

  // bit 8 selects whether the encoder chained with XOR or XNOR
  always_comb begin
    o_data    = '0;
    o_data[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_sym[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - per-channel TMDS word aligner and symbol decoder
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic             i_hdmi_clk,
  input  logic             i_reset_n,
  input  logic [SYM_W-1:0] i_raw,
  output logic [7:0]       o_data,
  output logic [1:0]       o_ctrl,
  output logic             o_de,
  output logic             o_locked,
  output logic [3:0]       o_offset
);

  localparam int RUN_W   = $clog2(LOCK_COUNT) + 1;
  localparam int CYC_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;

  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(LOCK_COUNT - 1);
  localparam logic [CYC_W-1:0] SEARCH_LAST = CYC_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] LOSS_LAST   = CYC_W'(LOSS_TIMEOUT - 1);

  tmds_state_t      r_state;
  tmds_state_t      w_state_next;
  logic [SYM_W-1:0] r_raw_q;
  logic [SYM_W-1:0] r_sym_q;
  logic [3:0]       r_offset;
  logic [3:0]       w_offset_next;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_next;
  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] w_cyc_next;
  logic             w_refresh;

  logic [7:0]       r_data;
  logic [1:0]       r_ctrl;
  logic             r_de;
  logic             r_locked;

  logic [2*SYM_W-1:0] w_combined;
  logic [SYM_W-1:0]   w_window;
  logic               w_is_ctrl;
  logic [1:0]         w_ctrl;
  logic [7:0]         w_data;

  // older word sits in the low half, so the stream reads upward from bit 0
  assign w_combined = {i_raw, r_raw_q};
  assign w_window   = w_combined[r_offset +: SYM_W];

  tmds_symbol_decode u_symbol_decode (
    .i_sym     (r_sym_q),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl),
    .o_data    (w_data)
  );

  assign w_run_inc = w_is_ctrl ? ((r_run == RUN_FULL) ? r_run : r_run + RUN_W'(1)) : '0;
  assign w_refresh = (w_run_inc == RUN_FULL);

  always_comb begin
    w_state_next  = r_state;
    w_cyc_next    = r_cyc + CYC_W'(1);
    w_run_next    = w_run_inc;
    w_offset_next = r_offset;
    case (r_state)
      SEARCH: begin
        if (w_is_ctrl && (r_run == RUN_LAST)) begin
          w_state_next = LOCKED;
          w_cyc_next   = '0;
        end else if (r_cyc == SEARCH_LAST) begin
          w_offset_next = (r_offset == OFFSET_MAX) ? 4'd0 : r_offset + 4'd1;
          w_cyc_next    = '0;
          w_run_next    = '0;
        end
      end
      LOCKED: begin
        if (w_refresh) begin
          w_cyc_next = '0;
        end else if (r_cyc == LOSS_LAST) begin
          w_state_next = SEARCH;
          w_cyc_next   = '0;
          w_run_next   = '0;
        end
      end
      default: begin
        w_state_next = SEARCH;
        w_cyc_next   = '0;
        w_run_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= SEARCH;
      r_raw_q  <= '0;
      r_sym_q  <= '0;
      r_offset <= '0;
      r_run    <= '0;
      r_cyc    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_raw_q  <= i_raw;
      r_sym_q  <= w_window;
      r_offset <= w_offset_next;
      r_run    <= w_run_next;
      r_cyc    <= w_cyc_next;
    end
  end

  // outputs follow the post-edge lock state so o_de never asserts without o_locked
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data   <= '0;
      r_ctrl   <= '0;
      r_de     <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= (w_state_next == LOCKED);
      if (w_state_next == LOCKED) begin
        if (w_is_ctrl) begin
          r_de   <= 1'b0;
          r_ctrl <= w_ctrl;
          r_data <= '0;
        end else begin
          r_de   <= 1'b1;
          r_data <= w_data;
        end
      end else begin
        r_de   <= 1'b0;
        r_ctrl <= '0;
        r_data <= '0;
      end
    end
  end

  assign o_data   = r_data;
  assign o_ctrl   = r_ctrl;
  assign o_de     = r_de;
  assign o_locked = r_locked;
  assign o_offset = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - scoreboard bench for tmds_decoder against a bit-stream reference model
module tb_tmds_decoder;

  localparam int LC = 8;
  localparam int ST = 64;
  localparam int LT = 128;

  logic       clk;
  logic       i_reset_n;
  logic [9:0] i_raw;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_offset;

  tmds_decoder #(
    .LOCK_COUNT     (LC),
    .SEARCH_TIMEOUT (ST),
    .LOSS_TIMEOUT   (LT)
  ) dut (
    .i_hdmi_clk (clk),
    .i_reset_n  (i_reset_n),
    .i_raw      (i_raw),
    .o_data     (o_data),
    .o_ctrl     (o_ctrl),
    .o_de       (o_de),
    .o_locked   (o_locked),
    .o_offset   (o_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [7:0] dec_lut [1024];

  bit          bitq [$];
  bit          hist [$];
  logic [15:0] exp_q [$];

  logic [9:0] m_sym;
  bit         m_locked;
  int         m_run, m_cyc, m_off;
  logic [1:0] m_ctrl;
  logic [7:0] m_data;
  bit         m_de;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, got, want);
    end
  endfunction

  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input bit xm, input bit inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xm ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {inv, xm, (inv ? ~qm : qm)};
  endfunction

  function automatic bit is_token(input logic [9:0] s);
    for (int t = 0; t < 4; t++) if (s == tok[t]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rand_data_sym();
    logic [9:0] s;
    do s = tmds_enc(8'($urandom), 1'($urandom), 1'($urandom)); while (is_token(s));
    return s;
  endfunction

  function automatic void push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
  endfunction

  function automatic void model_reset();
    hist.delete();
    repeat (10) hist.push_back(1'b0);
    m_sym = '0; m_locked = 0; m_run = 0; m_cyc = 0; m_off = 0;
    m_ctrl = '0; m_data = '0; m_de = 0;
  endfunction

  // one clock edge of the receiver, derived from the transmitted bit history
  function automatic void model_step(input logic [9:0] w);
    bit         is_c, lk_n;
    logic [1:0] c;
    int         run_n, cyc_n, off_n;
    logic [9:0] win;
    is_c = 0; c = '0;
    for (int t = 0; t < 4; t++) if (m_sym == tok[t]) begin is_c = 1; c = 2'(t); end
    run_n = is_c ? ((m_run < LC) ? m_run + 1 : LC) : 0;
    lk_n = m_locked; cyc_n = m_cyc + 1; off_n = m_off;
    if (!m_locked) begin
      if (is_c && m_run == LC - 1) begin lk_n = 1; cyc_n = 0; end
      else if (m_cyc == ST - 1) begin off_n = (m_off + 1) % 10; cyc_n = 0; run_n = 0; end
    end else if (run_n == LC) cyc_n = 0;
    else if (m_cyc == LT - 1) begin lk_n = 0; cyc_n = 0; run_n = 0; end
    if (lk_n) begin
      if (is_c) begin m_de = 0; m_ctrl = c; m_data = '0; end
      else begin m_de = 1; m_data = dec_lut[m_sym]; end
    end else begin
      m_de = 0; m_ctrl = '0; m_data = '0;
    end
    for (int i = 0; i < 10; i++) hist.push_back(w[i]);
    for (int i = 0; i < 10; i++) win[i] = hist[m_off + i];
    repeat (10) void'(hist.pop_front());
    m_sym = win; m_locked = lk_n; m_run = run_n; m_cyc = cyc_n; m_off = off_n;
    exp_q.push_back({m_locked, 4'(m_off), m_de, m_ctrl, m_data});
  endfunction

  task automatic drive_next();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'($urandom);
    i_raw = w;
    @(posedge clk);
    model_step(w);
    #1;
    edge_n++;
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    exp_q.delete();
    bitq.delete();
    #1;
    check("reset_data", 32'(o_data), 32'h0);
    check("reset_ctrl", 32'(o_ctrl), 32'h0);
    check("reset_de", 32'(o_de), 32'h0);
    check("reset_locked", 32'(o_locked), 32'h0);
    check("reset_offset", 32'(o_offset), 32'h0);
    i_raw = 10'($urandom);
    repeat (2) @(posedge clk);
    #3;
    i_reset_n = 1'b1;
    model_reset();
    edge_n = 0;
    check("release_locked", 32'(o_locked), 32'h0);
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", 32'({o_locked, o_offset, o_de, o_ctrl, o_data}), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog edge=%0d got=timeout expected=finish", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  lock_cnt, drops, prev_off, lock_edge;
    bit  wrap_seen;
    i_reset_n = 1'b1;
    i_raw     = '0;
    for (int d = 0; d < 256; d++)
      for (int m = 0; m < 4; m++) dec_lut[tmds_enc(8'(d), m[0], m[1])] = 8'(d);
    #3;

    // aligned lock, then 0x5A and a random tail
    apply_reset();
    repeat (16) push_sym(tok[0]);
    push_sym(tmds_enc(8'h5A, 1'b1, 1'b0));
    for (int k = 0; k < 40; k++) push_sym(($urandom_range(0, 9) < 3) ? tok[$urandom_range(0, 3)] : rand_data_sym());
    while (bitq.size() >= 10) begin
      drive_next();
      if (edge_n == 9) check("aligned_prelock", 32'(o_locked), 32'h0);
      if (edge_n == 10) begin
        check("aligned_lock", 32'(o_locked), 32'h1);
        check("aligned_ctrl", 32'(o_ctrl), 32'h0);
        check("aligned_de0", 32'(o_de), 32'h0);
      end
      if (edge_n == 19) begin
        check("aligned_data", 32'(o_data), 32'h5A);
        check("aligned_de1", 32'(o_de), 32'h1);
      end
    end

    // stream delayed by three bits: hunt must settle on offset 3
    apply_reset();
    repeat (3) bitq.push_back(1'($urandom));
    repeat (230) push_sym(tok[2]);
    lock_edge = -1;
    while (bitq.size() >= 10) begin
      drive_next();
      if (lock_edge < 0 && o_locked) begin
        lock_edge = edge_n;
        check("misalign_offset", 32'(o_offset), 32'h3);
        check("misalign_ctrl", 32'(o_ctrl), 32'h2);
      end
    end
    check("misalign_lock_edge", 32'(lock_edge), 32'd201);

    // seven-token runs never qualify; offset keeps hunting and wraps
    apply_reset();
    for (int g = 0; g < 90; g++) begin
      repeat (7) push_sym(tok[0]);
      push_sym(rand_data_sym());
    end
    lock_cnt = 0; wrap_seen = 0; prev_off = 0;
    while (bitq.size() >= 10) begin
      drive_next();
      if (o_locked) lock_cnt++;
      if (prev_off == 9 && o_offset == 4'd0) wrap_seen = 1;
      prev_off = int'(o_offset);
    end
    check("run7_never_locks", 32'(lock_cnt), 32'd0);
    check("offset_wraps", 32'(wrap_seen), 32'd1);

    // loss after LOSS_TIMEOUT data-only cycles, then relock
    apply_reset();
    repeat (12) push_sym(tok[$urandom_range(0, 3)]);
    repeat (160) push_sym(rand_data_sym());
    repeat (10) push_sym(tok[1]);
    repeat (20) push_sym(rand_data_sym());
    while (bitq.size() >= 10) begin
      drive_next();
      if (edge_n == 141) check("loss_still_locked", 32'(o_locked), 32'h1);
      if (edge_n == 142) begin
        check("loss_unlocked", 32'(o_locked), 32'h0);
        check("loss_offset_kept", 32'(o_offset), 32'h0);
        check("loss_de", 32'(o_de), 32'h0);
        check("loss_data", 32'(o_data), 32'h0);
      end
      if (edge_n == 181) check("relock_pending", 32'(o_locked), 32'h0);
      if (edge_n == 182) check("relock", 32'(o_locked), 32'h1);
    end

    // periodic refresh every 100 cycles keeps lock
    apply_reset();
    repeat (5) begin
      repeat (8) push_sym(tok[$urandom_range(0, 3)]);
      repeat (92) push_sym(rand_data_sym());
    end
    drops = 0;
    while (bitq.size() >= 10) begin
      drive_next();
      if (edge_n >= 10 && !o_locked) drops++;
    end
    check("refresh_no_drop", 32'(drops), 32'd0);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
